// File: rtl/me_ctrl.sv
// ---------------------------------------------------------------------------
// me_ctrl -- player ("me") state controller
//
// Holds the registered player position, visibility, remaining lives and the
// game-over flag. Position moves one STEP per video frame from the direction
// keys and is clamped to the play field. A collision in ALIVE costs a life and
// opens an invincibility window (INV); losing the last life enters OVER, which
// holds until restart.
//
// Optional build macro:
//   ME_BLINK_EN  -- when defined the player blinks during INV
//                   (me_vi follows inv_cnt[2], period 8 frames);
//                   when undefined me_vi stays 1 in INV.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse per video frame (assert at vertical blank)
//   key_left    in   level-sensitive direction key, x decreases
//   key_right   in   level-sensitive direction key, x increases
//   key_up      in   level-sensitive direction key, y decreases
//   key_down    in   level-sensitive direction key, y increases
//   hit         in   one-cycle collision pulse
//   restart     in   one-cycle pulse, reloads all reset values
//   me_x        out  player x relative to play-field left edge (9 bits)
//   me_y        out  player y (9 bits)
//   me_vi       out  player visible
//   me_lifes    out  remaining lives (3 bits)
//   game_over   out  high while in OVER
// ---------------------------------------------------------------------------
module me_ctrl #(
    parameter int ME_W       = 32,
    parameter int ME_H       = 32,
    parameter int X_INIT     = 144,
    parameter int Y_INIT     = 400,
    parameter int STEP       = 4,
    parameter int X_MAX      = 320 - ME_W,
    parameter int Y_MAX      = 480 - ME_H,
    parameter int LIFES_INIT = 3,
    parameter int INV_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       hit,
    input  logic       restart,
    output logic [8:0] me_x,
    output logic [8:0] me_y,
    output logic       me_vi,
    output logic [2:0] me_lifes,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        INV   = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [9:0] STEP_W     = 10'(STEP);
    localparam logic [9:0] X_MAX_W    = 10'(X_MAX);
    localparam logic [9:0] Y_MAX_W    = 10'(Y_MAX);
    localparam logic [8:0] X_INIT_W   = 9'(X_INIT);
    localparam logic [8:0] Y_INIT_W   = 9'(Y_INIT);
    localparam logic [2:0] LIFES_W    = 3'(LIFES_INIT);
    localparam logic [7:0] INV_INIT_W = 8'(INV_FRAMES);

    state_t     state, next_state;
    logic [7:0] inv_cnt, next_inv_cnt;
    logic [8:0] next_x, next_y;
    logic [2:0] next_lifes;
    logic       next_vi, next_game_over;

    // One axis of movement. The sum is formed 10 bits wide so that a move
    // past the upper limit is seen before it wraps, then clamped to the limit;
    // a move below zero is clamped to 0.
    function automatic logic [8:0] move_axis(input logic [8:0] pos,
                                             input logic       inc,
                                             input logic       dec,
                                             input logic [9:0] limit);
        logic [9:0] wide;
        logic [9:0] sum;
        wide      = {1'b0, pos};
        sum       = wide + STEP_W;
        move_axis = pos;
        if (inc && !dec) begin
            if (sum > limit)
                move_axis = limit[8:0];
            else
                move_axis = sum[8:0];
        end else if (dec && !inc) begin
            if (wide < STEP_W)
                move_axis = 9'd0;
            else
                move_axis = pos - STEP_W[8:0];
        end
    endfunction

    // State and output registers; everything visible outside is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALIVE;
            inv_cnt   <= 8'd0;
            me_x      <= X_INIT_W;
            me_y      <= Y_INIT_W;
            me_lifes  <= LIFES_W;
            me_vi     <= 1'b1;
            game_over <= 1'b0;
        end else begin
            state     <= next_state;
            inv_cnt   <= next_inv_cnt;
            me_x      <= next_x;
            me_y      <= next_y;
            me_lifes  <= next_lifes;
            me_vi     <= next_vi;
            game_over <= next_game_over;
        end
    end

    // Next-state logic. Restart wins over everything else. In ALIVE a hit
    // switches to INV with a fresh counter, so a tick in the same cycle moves
    // the player but does not consume invincibility time.
    always_comb begin
        next_state   = state;
        next_inv_cnt = inv_cnt;
        next_x       = me_x;
        next_y       = me_y;
        next_lifes   = me_lifes;

        if (restart) begin
            next_state   = ALIVE;
            next_inv_cnt = 8'd0;
            next_x       = X_INIT_W;
            next_y       = Y_INIT_W;
            next_lifes   = LIFES_W;
        end else begin
            case (state)
                ALIVE: begin
                    if (frame_tick) begin
                        next_x = move_axis(me_x, key_right, key_left, X_MAX_W);
                        next_y = move_axis(me_y, key_down, key_up, Y_MAX_W);
                    end
                    if (hit && me_lifes != 3'd0) begin
                        next_lifes = me_lifes - 3'd1;
                        if (me_lifes == 3'd1) begin
                            next_state = OVER;
                        end else begin
                            next_state   = INV;
                            next_inv_cnt = INV_INIT_W;
                        end
                    end
                end
                INV: begin
                    if (frame_tick) begin
                        next_x       = move_axis(me_x, key_right, key_left, X_MAX_W);
                        next_y       = move_axis(me_y, key_down, key_up, Y_MAX_W);
                        next_inv_cnt = inv_cnt - 8'd1;
                        if (inv_cnt == 8'd1)
                            next_state = ALIVE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Visibility and game-over are derived from the next state so they land
    // in their registers together with it.
    always_comb begin
        next_vi        = 1'b1;
        next_game_over = 1'b0;
        if (next_state == OVER) begin
            next_vi        = 1'b0;
            next_game_over = 1'b1;
        end else if (next_state == INV) begin
`ifdef ME_BLINK_EN
            next_vi = next_inv_cnt[2];
`else
            next_vi = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_me_ctrl.sv
// ---------------------------------------------------------------------------
// tb_me_ctrl -- self-checking bench for me_ctrl
//
// A behavioural model of the player (integer position, life count, mode and
// remaining invincibility frames) is stepped alongside the DUT and every
// output is compared each cycle. Directed sequences cover movement, clamping,
// hits, invincibility length, game over, restart and async reset; a random
// phase follows.
// ---------------------------------------------------------------------------
module tb_me_ctrl;

    localparam int X_INIT = 144;
    localparam int Y_INIT = 400;
    localparam int STEP   = 4;
    localparam int X_MAX  = 320 - 32;
    localparam int Y_MAX  = 480 - 32;
    localparam int LIVES  = 3;
    localparam int INV_N  = 120;

    localparam int M_ALIVE = 0;
    localparam int M_INV   = 1;
    localparam int M_OVER  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, key_left, key_right, key_up, key_down, hit, restart;
    logic [8:0] me_x, me_y;
    logic       me_vi;
    logic [2:0] me_lifes;
    logic       game_over;

    int err_count   = 0;
    int check_count = 0;

    int m_x, m_y, m_lives, m_mode, m_inv;

    me_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_up     (key_up),
        .key_down   (key_down),
        .hit        (hit),
        .restart    (restart),
        .me_x       (me_x),
        .me_y       (me_y),
        .me_vi      (me_vi),
        .me_lifes   (me_lifes),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_x     = X_INIT;
        m_y     = Y_INIT;
        m_lives = LIVES;
        m_mode  = M_ALIVE;
        m_inv   = 0;
    endtask

    function automatic int model_vi();
        if (m_mode == M_OVER) return 0;
        if (m_mode == M_INV) begin
`ifdef ME_BLINK_EN
            return (m_inv / 4) % 2;
`else
            return 1;
`endif
        end
        return 1;
    endfunction

    function automatic int moved(input int pos, input int plus, input int minus, input int lim);
        if (plus && !minus) return (pos + STEP > lim) ? lim : pos + STEP;
        if (minus && !plus) return (pos < STEP) ? 0 : pos - STEP;
        return pos;
    endfunction

    task automatic compare_all();
        checkOutput("me_x", int'(me_x), m_x);
        checkOutput("me_y", int'(me_y), m_y);
        checkOutput("me_lifes", int'(me_lifes), m_lives);
        checkOutput("me_vi", int'(me_vi), model_vi());
        checkOutput("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
    endtask

    // One clock cycle: drive inputs, advance model on the edge, compare 1 ns later.
    task automatic applyStimulus(input bit tk, input bit l, input bit r, input bit u,
                                 input bit d, input bit h, input bit rs);
        frame_tick = tk; key_left = l; key_right = r; key_up = u; key_down = d;
        hit = h; restart = rs;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (m_mode != M_OVER) begin
            if (tk) begin
                m_x = moved(m_x, r, l, X_MAX);
                m_y = moved(m_y, d, u, Y_MAX);
            end
            if (m_mode == M_ALIVE && h) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = M_OVER;
                else begin
                    m_mode = M_INV;
                    m_inv  = INV_N;
                end
            end else if (m_mode == M_INV && tk) begin
                m_inv = m_inv - 1;
                if (m_inv == 0) m_mode = M_ALIVE;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic frames(input int n, input bit l, input bit r, input bit u, input bit d);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, l, r, u, d, 1'b0, 1'b0);
            applyStimulus(1'b0, l, r, u, d, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 0; key_left = 0; key_right = 0; key_up = 0; key_down = 0;
        hit = 0; restart = 0;
        model_reset();
        #3;
        checkOutput("reset_x", int'(me_x), 144);
        checkOutput("reset_y", int'(me_y), 400);
        checkOutput("reset_vi", int'(me_vi), 1);
        checkOutput("reset_lifes", int'(me_lifes), 3);
        checkOutput("reset_over", int'(game_over), 0);
        #9 rst = 1'b0;

        // Ten frames right from 144
        frames(10, 0, 1, 0, 0);
        checkOutput("right10_x", int'(me_x), 184);
        checkOutput("right10_y", int'(me_y), 400);

        // Left clamp at 0
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        frames(36, 1, 0, 0, 0);
        checkOutput("left36_x", int'(me_x), 0);
        frames(4, 1, 0, 0, 0);
        checkOutput("left40_x", int'(me_x), 0);

        // Right clamp at X_MAX, then both keys hold still
        frames(100, 0, 1, 0, 0);
        checkOutput("right_sat_x", int'(me_x), 288);
        frames(5, 1, 1, 0, 0);
        checkOutput("both_keys_x", int'(me_x), 288);
        frames(120, 0, 0, 0, 1);
        checkOutput("down_sat_y", int'(me_y), 448);

        // Hit, ignored hit during INV, window expiry
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("hit1_lifes", int'(me_lifes), 2);
        frames(5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("inv_hit_lifes", int'(me_lifes), 2);
        frames(115, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("hit2_lifes", int'(me_lifes), 1);

        // Last life, game over, frozen
        frames(120, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("over_lifes", int'(me_lifes), 0);
        checkOutput("over_flag", int'(game_over), 1);
        checkOutput("over_vi", int'(me_vi), 0);
        frames(6, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("restart_x", int'(me_x), 144);
        checkOutput("restart_y", int'(me_y), 400);
        checkOutput("restart_lifes", int'(me_lifes), 3);
        checkOutput("restart_over", int'(game_over), 0);

        // Same-cycle hit and tick: move applied, counter starts full
        applyStimulus(1, 0, 0, 1, 0, 1, 0);
        checkOutput("hit_tick_y", int'(me_y), 396);
        checkOutput("hit_tick_lifes", int'(me_lifes), 2);
        frames(119, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("inv119_lifes", int'(me_lifes), 2);
        frames(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("inv120_lifes", int'(me_lifes), 1);

        // Restart beats hit in the same cycle
        applyStimulus(1, 0, 1, 0, 0, 1, 1);
        checkOutput("restart_prio_lifes", int'(me_lifes), 3);

        // Async reset mid-INV
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        frames(7, 0, 1, 0, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checkOutput("arst_x", int'(me_x), 144);
        checkOutput("arst_y", int'(me_y), 400);
        checkOutput("arst_lifes", int'(me_lifes), 3);
        checkOutput("arst_vi", int'(me_vi), 1);
        checkOutput("arst_over", int'(game_over), 0);
        #2 rst = 1'b0;

        // Random phase against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 399) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/me_ctrl.md
# me_ctrl

Player ("me") state controller: owns the registered player position, visibility, remaining lives and game-over flag consumed by the player sprite address generator and the life-icon overlay. Position moves one step per video frame from the key inputs, clamped to the 320-pixel play field (screen columns 160–479). Collision pulses decrement lives, start an invincibility window, and finally enter game over until restart.

## Interface
Parameters:
- `X_INIT`, default 144: reset and restart x, relative to play-field left edge.
- `Y_INIT`, default 400: reset and restart y.
- `STEP`, default 4: pixels moved per frame per axis.
- `X_MAX`, default 320 − `ME_W`: largest legal x.
- `Y_MAX`, default 480 − `ME_H`: largest legal y. `ME_W` and `ME_H` come from config.h.
- `LIFES_INIT`, default 3: lives at reset and restart, range 1–7.
- `INV_FRAMES`, default 120: invincibility length in frames, range 1–255.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse once per video frame.
- `key_left`, `key_right`, `key_up`, `key_down` in 1 each: level-sensitive direction keys.
- `hit` in 1: one-cycle collision pulse.
- `restart` in 1: one-cycle pulse that restarts the game.
- `me_x` out 9: player x.
- `me_y` out 9: player y.
- `me_vi` out 1: player visible.
- `me_lifes` out 3: remaining lives.
- `game_over` out 1: high in OVER state.

## Operation
- States:
  - ALIVE: moves; a hit is accepted.
  - INV: moves; a hit is ignored.
  - OVER: frozen, hidden.
- ALIVE + `hit`:
  - `me_lifes` decrements.
  - If the result is 0, go to OVER.
  - Otherwise go to INV with `inv_cnt` = `INV_FRAMES`.
- INV:
  - Each `frame_tick` decrements `inv_cnt`.
  - On a tick that takes `inv_cnt` from 1 to 0, go to ALIVE.
  - `hit` is ignored.
- OVER:
  - `game_over` = 1, `me_vi` = 0.
  - Keys and `hit` are ignored.
- `restart`, accepted in any state, loads all reset values in one cycle.
  - `restart` takes priority over `hit` and `frame_tick` in the same cycle.
- Movement, evaluated only on `frame_tick` in ALIVE or INV:
  - x: `key_right` alone gives x + `STEP`; `key_left` alone gives x − `STEP`; both or neither gives no change.
  - y: same rule, with `key_down` adding and `key_up` subtracting.
  - Arithmetic is done 10 bits wide.
  - Subtraction saturates at 0: if x < `STEP`, x becomes 0.
  - Addition saturates at `X_MAX` or `Y_MAX`.
  - The x and y axes are independent, so diagonal moves are allowed.
- Same-cycle `hit` and `frame_tick` in ALIVE:
  - The move is applied.
  - The state transition is taken.
  - The new INV counter starts at `INV_FRAMES`; this tick does not decrement it.
- `me_lifes` never underflows; OVER is entered exactly when it reaches 0.

## Timing
- All outputs are registered.
- Reset values:
  - `me_x` = `X_INIT`, `me_y` = `Y_INIT`.
  - `me_vi` = 1, `me_lifes` = `LIFES_INIT`, `game_over` = 0.
  - State ALIVE, `inv_cnt` = 0.
- Latency: an input sampled on edge N (`frame_tick`, `hit`, `restart`) is visible on the outputs after edge N.
- The block does not itself gate updates to blanking. `frame_tick` must be asserted at vertical blank so the sprite does not tear mid-frame.
- Reset asserted mid-game clears the block immediately (asynchronously), independent of `clk`.

## Configuration
- `ME_BLINK_EN`:
  - Defined: in INV, `me_vi` = `inv_cnt[2]`, so the player blinks with a period of 8 frames.
  - Undefined: `me_vi` = 1 in INV.
- ALIVE and OVER behaviour is identical either way.

## Test plan
- Reset, then 10 ticks with `key_right` held → `me_x` = 184, `me_y` = 400, `me_vi` = 1, `me_lifes` = 3.
- `key_left` held for 40 ticks from x = 144 → x reaches 0 after the 36th tick and stays 0. `key_right` held for 100 ticks → x saturates at `X_MAX`. Both keys held → x unchanged.
- `hit` in ALIVE → `me_lifes` = 2, state INV. A second `hit` 5 frames later → `me_lifes` still 2. After 120 ticks → ALIVE; the next `hit` → `me_lifes` = 1.
- With `ME_BLINK_EN` defined, during INV → `me_vi` toggles every 4 ticks. With it undefined → `me_vi` stays 1.
- Three accepted hits → `me_lifes` = 0, `game_over` = 1, `me_vi` = 0; keys do not change x or y. `restart` → `me_x` = 144, `me_y` = 400, `me_lifes` = 3, `game_over` = 0.
- `hit` and `frame_tick` in the same cycle with `key_up` held → `me_y` = 396, `me_lifes` decremented, `inv_cnt` = 120. `rst` pulsed mid-INV → all reset values immediately.
